pe_conf_seq: RTL and testbench

Per-PE context sequencer for the CGRA array. It holds a small program of PE configuration words and replays it for a programmed number of iterations. It drives the PE's `conf` and `en` inputs each cycle and consumes the PE's `branch_out` as an early-exit request. It sits directly upstream of each PE and is loaded by the array controller before a kernel launch.

---
 rtl/pe_conf_seq_pkg.sv | 16 +
 rtl/pe_conf_seq_mem.sv | 27 ++
 rtl/pe_conf_seq.sv | 142 ++++++++++++++
 tb/tb_pe_conf_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_conf_seq_pkg.sv
// Shared definitions for the per-PE context sequencer: FSM states and
// default geometry of the context store.
package pe_conf_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CONF_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int ITER_WIDTH     = 8;

endpackage

// File: rtl/pe_conf_seq_mem.sv
// Context word store: one synchronous write port, one combinational read
// port. Contents are deliberately not reset so a loaded program survives rst.
module conf_mem
  import pe_conf_seq_pkg::*;
#(
  parameter int CONF_WIDTH = CONF_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [CONF_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [CONF_WIDTH-1:0] rdata
);

  logic [CONF_WIDTH-1:0] mem [DEPTH];

  // Write port: one word per enabled edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_conf_seq.sv
// Per-PE context sequencer: replays slots 0..last_addr of the context store
// for a captured number of iterations, driving the PE conf/en inputs and
// honouring stall and an early-exit request from the PE.
module pe_conf_seq
  import pe_conf_seq_pkg::*;
#(
  parameter int CONF_WIDTH = CONF_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [CONF_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [ITER_WIDTH-1:0] iter,
  input  logic                  stall,
  input  logic                  branch_in,
  output logic [CONF_WIDTH-1:0] conf,
  output logic                  en,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [ITER_WIDTH-1:0] rem;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CONF_WIDTH-1:0] mem_rdata;
  logic [CONF_WIDTH-1:0] rd_word;

  // The store is only writable while idle, so a running program is immutable
  assign mem_we = load_valid && (state == ST_IDLE);

  // Next slot to present: pc+1 inside a pass, otherwise slot 0 (launch or wrap)
  always_comb begin
    rd_addr = '0;
    if ((state == ST_RUN) && (pc != last_q)) rd_addr = pc + 1'b1;
  end

  // Write-first bypass so a same-edge load of slot 0 is the first word issued
  always_comb begin
    rd_word = mem_rdata;
    if (mem_we && (load_addr == rd_addr)) rd_word = load_data;
  end

  conf_mem #(
    .CONF_WIDTH (CONF_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_conf_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // Sequencer FSM with registered outputs; rem counts iterations including the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      conf   <= '0;
      en     <= 1'b0;
      pc     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      last_q <= '0;
      rem    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          conf <= '0;
          en   <= 1'b0;
          pc   <= '0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (iter != '0) begin
              state  <= ST_RUN;
              last_q <= last_addr;
              rem    <= iter;
              conf   <= rd_word;
              en     <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (stall) begin
            // Hold slot and iteration count, just gate the PE
            en <= 1'b0;
          end else if (branch_in || ((pc == last_q) && (rem <= ITER_WIDTH'(1)))) begin
            state <= ST_DONE;
            conf  <= '0;
            en    <= 1'b0;
            pc    <= '0;
            done  <= 1'b1;
            rem   <= '0;
          end else begin
            conf <= rd_word;
            en   <= 1'b1;
            if (pc != last_q) begin
              pc <= pc + 1'b1;
            end else begin
              pc  <= '0;
              rem <= rem - 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          conf  <= '0;
          en    <= 1'b0;
          pc    <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          conf  <= '0;
          en    <= 1'b0;
          pc    <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_conf_seq.sv
// Randomized bench for pe_conf_seq against a flat-list reference model:
// a launch expands the program into the full list of contexts to issue,
// and each cycle either holds (stall), abandons (branch) or steps along it.
module tb_pe_conf_seq;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic [3:0] last_addr;
  logic [7:0] iter;
  logic       stall;
  logic       branch_in;
  logic [7:0] conf;
  logic       en;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  pe_conf_seq dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .last_addr  (last_addr),
    .iter       (iter),
    .stall      (stall),
    .branch_in  (branch_in),
    .conf       (conf),
    .en         (en),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 idle, 1 run, 2 done
  logic [7:0] m_mem [16];
  logic [7:0] m_flat [$];
  int         m_state = 0;
  int         m_idx   = 0;
  int         m_last  = 0;
  logic       m_en    = 1'b0;

  int en_cnt  = 0;
  int seen33  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_conf;
    logic       e_en;
    logic [3:0] e_pc;
    e_conf = 8'h00;
    e_en   = 1'b0;
    e_pc   = 4'h0;
    if (m_state == 1) begin
      e_conf = m_flat[m_idx];
      e_en   = m_en;
      e_pc   = 4'(m_idx % (m_last + 1));
    end
    check("conf", 32'(conf), 32'(e_conf));
    check("en",   32'(en),   32'(e_en));
    check("pc",   32'(pc),   32'(e_pc));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("done", 32'(done), 32'(m_state == 2));
  endtask

  task automatic model_step(input logic lv, input logic [3:0] la, input logic [7:0] ld,
                            input logic st, input logic [3:0] lst, input logic [7:0] it,
                            input logic sl, input logic br);
    case (m_state)
      0: begin
        if (lv) m_mem[la] = ld;
        if (st) begin
          if (it == 8'd0) begin
            m_state = 2;
          end else begin
            m_flat.delete();
            for (int r = 0; r < int'(it); r++)
              for (int a = 0; a <= int'(lst); a++)
                m_flat.push_back(m_mem[a]);
            m_last  = int'(lst);
            m_idx   = 0;
            m_en    = 1'b1;
            m_state = 1;
          end
        end
      end
      1: begin
        if (sl) begin
          m_en = 1'b0;
        end else if (br) begin
          m_state = 2;
        end else begin
          m_idx++;
          if (m_idx >= m_flat.size()) m_state = 2;
          else m_en = 1'b1;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // drive one cycle of inputs just after a falling edge, check at the next one
  task automatic step(input logic lv, input logic [3:0] la, input logic [7:0] ld,
                      input logic st, input logic [3:0] lst, input logic [7:0] it,
                      input logic sl, input logic br);
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    start      = st;
    last_addr  = lst;
    iter       = it;
    stall      = sl;
    branch_in  = br;
    model_step(lv, la, ld, st, lst, it, sl, br);
    @(negedge clk);
    check_outputs();
    if (en) en_cnt++;
    if (en && conf == 8'h33) seen33++;
  endtask

  task automatic idle_step();
    step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic launch(input logic [3:0] lst, input logic [7:0] it);
    en_cnt = 0;
    seen33 = 0;
    step(1'b0, 4'h0, 8'h00, 1'b1, lst, it, 1'b0, 1'b0);
  endtask

  // mode 0: random stall/branch; 1: two-cycle stall at slot 2 of pass one;
  // 2: branch at slot 1 of pass one
  task automatic run_until_idle(input int mode, input int stall_pct, input int br_pct, input bit junk);
    int   guard;
    int   stall_left;
    bit   fired;
    logic sl, br, lv, st;
    guard      = 0;
    stall_left = 0;
    fired      = 1'b0;
    while (m_state != 0 && guard < 500) begin
      sl = 1'b0;
      br = 1'b0;
      case (mode)
        1: begin
          if (!fired && m_state == 1 && m_idx == 2) begin
            fired      = 1'b1;
            stall_left = 2;
          end
          if (stall_left > 0) begin
            sl = 1'b1;
            stall_left--;
          end
        end
        2: begin
          if (!fired && m_state == 1 && m_idx == 1) begin
            fired = 1'b1;
            br    = 1'b1;
          end
        end
        default: begin
          sl = ($urandom_range(99) < stall_pct);
          br = ($urandom_range(99) < br_pct);
        end
      endcase
      lv = junk ? 1'($urandom_range(1)) : 1'b0;
      st = junk ? 1'($urandom_range(1)) : 1'b0;
      step(lv, 4'($urandom_range(15)), 8'($urandom_range(255)), st,
           4'($urandom_range(15)), 8'($urandom_range(255)), sl, br);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_timeout: sequencer still active after %0d cycles", guard);
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_addr  = 4'h0;
    load_data  = 8'h00;
    start      = 1'b0;
    last_addr  = 4'h0;
    iter       = 8'h00;
    stall      = 1'b0;
    branch_in  = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // basic program 11,22,33,44, two iterations
    for (int a = 0; a < 4; a++)
      step(1'b1, 4'(a), 8'(8'h11 * (a + 1)), 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    launch(4'd3, 8'd2);
    run_until_idle(0, 0, 0, 1'b0);
    check("basic_en_cycles", 32'(en_cnt), 32'((3 + 1) * 2));
    idle_step();

    // two-cycle stall while 0x33 is presented
    launch(4'd3, 8'd2);
    run_until_idle(1, 0, 0, 1'b0);
    check("stall_en_cycles", 32'(en_cnt), 32'd8);
    idle_step();

    // early exit at 0x22
    launch(4'd3, 8'd2);
    run_until_idle(2, 0, 0, 1'b0);
    check("branch_no_33", 32'(seen33), 32'd0);
    check("branch_en_cycles", 32'(en_cnt), 32'd2);
    idle_step();

    // zero iterations
    launch(4'd3, 8'd0);
    run_until_idle(0, 0, 0, 1'b0);
    check("iter0_en_cycles", 32'(en_cnt), 32'd0);

    // same-edge load of slot 0 and start
    en_cnt = 0;
    step(1'b1, 4'h0, 8'h5A, 1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    check("bypass_first_conf", 32'(conf), 32'h5A);
    run_until_idle(0, 0, 0, 1'b0);
    step(1'b1, 4'h0, 8'h11, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);

    // asynchronous reset in the middle of a run
    launch(4'd3, 8'd2);
    repeat (3) step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    m_state = 0;
    m_en    = 1'b0;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    launch(4'd3, 8'd2);
    run_until_idle(0, 0, 0, 1'b0);
    check("restart_en_cycles", 32'(en_cnt), 32'd8);

    // loads and starts during a run are ignored; replay proves memory intact
    launch(4'd3, 8'd2);
    run_until_idle(0, 0, 0, 1'b1);
    launch(4'd3, 8'd1);
    run_until_idle(0, 0, 0, 1'b0);
    check("after_junk_en_cycles", 32'(en_cnt), 32'd4);

    // randomized programs with random stall/branch
    for (int t = 0; t < 8; t++) begin
      logic [3:0] lst;
      logic [7:0] it;
      for (int k = 0; k < 6; k++)
        step(1'b1, 4'($urandom_range(15)), 8'($urandom_range(255)), 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
      lst = 4'($urandom_range(15));
      it  = 8'($urandom_range(3));
      launch(lst, it);
      run_until_idle(0, 20, 3, 1'b1);
      idle_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
